// File: rtl/lc3_pkg.sv
// Shared LC-3 encodings: opcodes, datapath mux selects and ISDU state codes.
package lc3_pkg;

  localparam logic [3:0] OP_BR    = 4'b0000;
  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_JSR   = 4'b0100;
  localparam logic [3:0] OP_AND   = 4'b0101;
  localparam logic [3:0] OP_LDR   = 4'b0110;
  localparam logic [3:0] OP_STR   = 4'b0111;
  localparam logic [3:0] OP_NOT   = 4'b1001;
  localparam logic [3:0] OP_JMP   = 4'b1100;
  localparam logic [3:0] OP_PAUSE = 4'b1101;

  localparam logic [1:0] PCMUX_INC  = 2'b00;
  localparam logic [1:0] PCMUX_BUS  = 2'b01;
  localparam logic [1:0] PCMUX_ADDR = 2'b10;

  localparam logic [1:0] ADDR2_ZERO  = 2'b00;
  localparam logic [1:0] ADDR2_OFF6  = 2'b01;
  localparam logic [1:0] ADDR2_OFF9  = 2'b10;
  localparam logic [1:0] ADDR2_OFF11 = 2'b11;

  localparam logic [1:0] ALUK_ADD   = 2'b00;
  localparam logic [1:0] ALUK_AND   = 2'b01;
  localparam logic [1:0] ALUK_NOT   = 2'b10;
  localparam logic [1:0] ALUK_PASSA = 2'b11;

  localparam logic [4:0] ST_HALTED = 5'd0;
  localparam logic [4:0] ST_S18    = 5'd1;
  localparam logic [4:0] ST_S33    = 5'd2;
  localparam logic [4:0] ST_S35    = 5'd3;
  localparam logic [4:0] ST_S32    = 5'd4;
  localparam logic [4:0] ST_S01    = 5'd5;
  localparam logic [4:0] ST_S05    = 5'd6;
  localparam logic [4:0] ST_S09    = 5'd7;
  localparam logic [4:0] ST_S00    = 5'd8;
  localparam logic [4:0] ST_S22    = 5'd9;
  localparam logic [4:0] ST_S12    = 5'd10;
  localparam logic [4:0] ST_S04    = 5'd11;
  localparam logic [4:0] ST_S21    = 5'd12;
  localparam logic [4:0] ST_S06    = 5'd13;
  localparam logic [4:0] ST_S07    = 5'd14;
  localparam logic [4:0] ST_S25    = 5'd15;
  localparam logic [4:0] ST_S27    = 5'd16;
  localparam logic [4:0] ST_S23    = 5'd17;
  localparam logic [4:0] ST_S16    = 5'd18;
  localparam logic [4:0] ST_PAUSE1 = 5'd19;
  localparam logic [4:0] ST_PAUSE2 = 5'd20;

  typedef enum logic [4:0] {
    HALTED = ST_HALTED, S18 = ST_S18, S33 = ST_S33, S35 = ST_S35,
    S32 = ST_S32, S01 = ST_S01, S05 = ST_S05, S09 = ST_S09,
    S00 = ST_S00, S22 = ST_S22, S12 = ST_S12, S04 = ST_S04,
    S21 = ST_S21, S06 = ST_S06, S07 = ST_S07, S25 = ST_S25,
    S27 = ST_S27, S23 = ST_S23, S16 = ST_S16,
    PAUSE1 = ST_PAUSE1, PAUSE2 = ST_PAUSE2
  } state_t;

  // States that hold the SRAM strobes for MEM_WAIT cycles.
  function automatic logic is_wait_state(state_t s);
    return (s == S33) || (s == S25) || (s == S16);
  endfunction

endpackage

// File: rtl/lc3_isdu_wait_ctr.sv
// Loadable down-counter that timestamps SRAM strobe duration; done while zero.
module isdu_wait_ctr #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (count != '0)
      count <= count - 1'b1;
  end

  assign done = (count == '0);

endmodule

// File: rtl/lc3_isdu.sv
// LC-3 instruction sequencer: Moore FSM driving datapath loads, gates, selects and SRAM strobes.
// Define ISDU_SINGLE_STEP_EN to pause after every executed instruction.
module lc3_isdu
  import lc3_pkg::*;
#(
  parameter int MEM_WAIT = 3,
  parameter int STATE_W  = 5
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Run,
  input  logic               Continue,
  input  logic [3:0]         Opcode,
  input  logic               IR_5,
  input  logic               IR_11,
  input  logic               BEN,
  output logic               LD_MAR,
  output logic               LD_MDR,
  output logic               LD_IR,
  output logic               LD_BEN,
  output logic               LD_CC,
  output logic               LD_REG,
  output logic               LD_PC,
  output logic               LD_LED,
  output logic               GatePC,
  output logic               GateMDR,
  output logic               GateALU,
  output logic               GateMARMUX,
  output logic [1:0]         PCMUX,
  output logic [1:0]         ADDR2MUX,
  output logic [1:0]         ALUK,
  output logic               DRMUX,
  output logic               SR1MUX,
  output logic               SR2MUX,
  output logic               ADDR1MUX,
  output logic               MARMUX,
  output logic               MIO_EN,
  output logic               Mem_CE,
  output logic               Mem_UB,
  output logic               Mem_LB,
  output logic               Mem_OE,
  output logic               Mem_WE,
  output logic [STATE_W-1:0] State
);

  localparam logic [3:0] WAIT_RELOAD = 4'(MEM_WAIT - 1);

  state_t state, state_nxt;
  logic   wait_done, wait_load, led_en;

`ifdef ISDU_SINGLE_STEP_EN
  localparam state_t EXEC_DONE = PAUSE1;
  logic step_pause;

  // Remembers whether PAUSE1 was reached by single-stepping rather than a PAUSE opcode.
  always_ff @(posedge Clk) begin
    if (Reset)
      step_pause <= 1'b0;
    else if (state_nxt == PAUSE1 && state != PAUSE1)
      step_pause <= (state != S32);
  end

  assign led_en = ~step_pause;
`else
  localparam state_t EXEC_DONE = S18;
  assign led_en = 1'b1;
`endif

  always_ff @(posedge Clk) begin
    if (Reset)
      state <= HALTED;
    else
      state <= state_nxt;
  end

  assign wait_load = is_wait_state(state_nxt) && (state_nxt != state);

  isdu_wait_ctr #(.W(4)) u_wait_ctr (
    .clk      (Clk),
    .reset    (Reset),
    .load     (wait_load),
    .load_val (WAIT_RELOAD),
    .done     (wait_done)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      HALTED: if (Run) state_nxt = S18;
      S18:    state_nxt = S33;
      S33:    if (wait_done) state_nxt = S35;
      S35:    state_nxt = S32;
      S32: begin
        case (Opcode)
          OP_ADD:   state_nxt = S01;
          OP_AND:   state_nxt = S05;
          OP_NOT:   state_nxt = S09;
          OP_BR:    state_nxt = S00;
          OP_JMP:   state_nxt = S12;
          OP_JSR:   state_nxt = S04;
          OP_LDR:   state_nxt = S06;
          OP_STR:   state_nxt = S07;
          OP_PAUSE: state_nxt = PAUSE1;
          default:  state_nxt = S18;
        endcase
      end
      S01, S05, S09, S22, S12, S21, S27: state_nxt = EXEC_DONE;
      S00:    state_nxt = BEN ? S22 : EXEC_DONE;
      S04:    state_nxt = S21;
      S06:    state_nxt = S25;
      S07:    state_nxt = S23;
      S25:    if (wait_done) state_nxt = S27;
      S23:    state_nxt = S16;
      S16:    if (wait_done) state_nxt = EXEC_DONE;
      PAUSE1: if (Continue) state_nxt = PAUSE2;
      PAUSE2: if (!Continue) state_nxt = S18;
      default: state_nxt = HALTED;
    endcase
  end

  always_comb begin
    LD_MAR = 1'b0; LD_MDR = 1'b0; LD_IR = 1'b0; LD_BEN = 1'b0;
    LD_CC = 1'b0; LD_REG = 1'b0; LD_PC = 1'b0; LD_LED = 1'b0;
    GatePC = 1'b0; GateMDR = 1'b0; GateALU = 1'b0; GateMARMUX = 1'b0;
    PCMUX = PCMUX_INC; ADDR2MUX = ADDR2_ZERO; ALUK = ALUK_ADD;
    DRMUX = 1'b0; SR1MUX = 1'b0; SR2MUX = 1'b0; ADDR1MUX = 1'b0;
    MARMUX = 1'b0; MIO_EN = 1'b0;
    Mem_OE = 1'b1; Mem_WE = 1'b1;
    case (state)
      S18: begin GatePC = 1'b1; LD_MAR = 1'b1; LD_PC = 1'b1; end
      S33, S25: begin Mem_OE = 1'b0; MIO_EN = 1'b1; LD_MDR = 1'b1; end
      S35: begin GateMDR = 1'b1; LD_IR = 1'b1; end
      S32: LD_BEN = 1'b1;
      S01, S05: begin
        SR1MUX = 1'b1; SR2MUX = IR_5;
        ALUK = (state == S05) ? ALUK_AND : ALUK_ADD;
        GateALU = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1;
      end
      S09: begin
        SR1MUX = 1'b1; ALUK = ALUK_NOT; GateALU = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1;
      end
      S22: begin ADDR2MUX = ADDR2_OFF9; PCMUX = PCMUX_ADDR; LD_PC = 1'b1; end
      S12: begin
        SR1MUX = 1'b1; ALUK = ALUK_PASSA; GateALU = 1'b1; PCMUX = PCMUX_BUS; LD_PC = 1'b1;
      end
      S04: begin GatePC = 1'b1; DRMUX = 1'b1; LD_REG = 1'b1; end
      S21: begin
        LD_PC = 1'b1;
        if (IR_11) begin
          ADDR2MUX = ADDR2_OFF11; PCMUX = PCMUX_ADDR;
        end else begin
          SR1MUX = 1'b1; ALUK = ALUK_PASSA; GateALU = 1'b1; PCMUX = PCMUX_BUS;
        end
      end
      S06, S07: begin
        ADDR1MUX = 1'b1; SR1MUX = 1'b1; ADDR2MUX = ADDR2_OFF6; GateMARMUX = 1'b1; LD_MAR = 1'b1;
      end
      S27: begin GateMDR = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1; end
      S23: begin ALUK = ALUK_PASSA; GateALU = 1'b1; LD_MDR = 1'b1; end
      S16: Mem_WE = 1'b0;
      PAUSE1: LD_LED = led_en;
      default: ;
    endcase
  end

  assign Mem_CE = 1'b0;
  assign Mem_UB = 1'b0;
  assign Mem_LB = 1'b0;
  assign State  = STATE_W'(state);

endmodule

// File: tb/tb_lc3_isdu.sv
// Self-checking bench for lc3_isdu: instruction-level expansion model plus directed literal checks.
module tb_lc3_isdu;
  import lc3_pkg::*;

  localparam int MW = 3;

  logic Clk = 1'b0;
  logic Reset, Run, Continue, IR_5, IR_11, BEN;
  logic [3:0] Opcode;
  logic LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
  logic GatePC, GateMDR, GateALU, GateMARMUX;
  logic [1:0] PCMUX, ADDR2MUX, ALUK;
  logic DRMUX, SR1MUX, SR2MUX, ADDR1MUX, MARMUX, MIO_EN;
  logic Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE;
  logic [4:0] State;

  always #5 Clk = ~Clk;

  lc3_isdu #(.MEM_WAIT(MW), .STATE_W(5)) dut (
    .Clk(Clk), .Reset(Reset), .Run(Run), .Continue(Continue), .Opcode(Opcode),
    .IR_5(IR_5), .IR_11(IR_11), .BEN(BEN),
    .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN), .LD_CC(LD_CC),
    .LD_REG(LD_REG), .LD_PC(LD_PC), .LD_LED(LD_LED),
    .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU), .GateMARMUX(GateMARMUX),
    .PCMUX(PCMUX), .ADDR2MUX(ADDR2MUX), .ALUK(ALUK),
    .DRMUX(DRMUX), .SR1MUX(SR1MUX), .SR2MUX(SR2MUX), .ADDR1MUX(ADDR1MUX),
    .MARMUX(MARMUX), .MIO_EN(MIO_EN),
    .Mem_CE(Mem_CE), .Mem_UB(Mem_UB), .Mem_LB(Mem_LB), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE),
    .State(State)
  );

  typedef struct packed {
    logic ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
    logic g_pc, g_mdr, g_alu, g_marmux;
    logic [1:0] pcmux, addr2mux, aluk;
    logic drmux, sr1mux, sr2mux, addr1mux, marmux, mio_en;
    logic ce, ub, lb, oe, we;
  } ctl_t;

  typedef struct {
    state_t st;
    logic   ir5;
    logic   ir11;
    logic   led;
  } step_t;

  ctl_t act;
  assign act = {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
                GatePC, GateMDR, GateALU, GateMARMUX, PCMUX, ADDR2MUX, ALUK,
                DRMUX, SR1MUX, SR2MUX, ADDR1MUX, MARMUX, MIO_EN,
                Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE};

  int nchk = 0;
  int nerr = 0;

  task automatic check(string nm, logic [31:0] a, logic [31:0] e);
    nchk++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask

  // Control word each micro-step must produce, straight from the step table.
  function automatic ctl_t exp_ctl(step_t s);
    ctl_t c = '0;
    c.oe = 1'b1; c.we = 1'b1;
    case (s.st)
      S18: begin c.g_pc = 1; c.ld_mar = 1; c.ld_pc = 1; end
      S33, S25: begin c.oe = 0; c.mio_en = 1; c.ld_mdr = 1; end
      S35: begin c.g_mdr = 1; c.ld_ir = 1; end
      S32: c.ld_ben = 1;
      S01: begin c.sr1mux = 1; c.sr2mux = s.ir5; c.aluk = 2'b00; c.g_alu = 1; c.ld_reg = 1; c.ld_cc = 1; end
      S05: begin c.sr1mux = 1; c.sr2mux = s.ir5; c.aluk = 2'b01; c.g_alu = 1; c.ld_reg = 1; c.ld_cc = 1; end
      S09: begin c.sr1mux = 1; c.aluk = 2'b10; c.g_alu = 1; c.ld_reg = 1; c.ld_cc = 1; end
      S22: begin c.addr2mux = 2'b10; c.pcmux = 2'b10; c.ld_pc = 1; end
      S12: begin c.sr1mux = 1; c.aluk = 2'b11; c.g_alu = 1; c.pcmux = 2'b01; c.ld_pc = 1; end
      S04: begin c.g_pc = 1; c.drmux = 1; c.ld_reg = 1; end
      S21: begin
        c.ld_pc = 1;
        if (s.ir11) begin c.addr2mux = 2'b11; c.pcmux = 2'b10; end
        else begin c.sr1mux = 1; c.aluk = 2'b11; c.g_alu = 1; c.pcmux = 2'b01; end
      end
      S06, S07: begin c.addr1mux = 1; c.sr1mux = 1; c.addr2mux = 2'b01; c.g_marmux = 1; c.ld_mar = 1; end
      S27: begin c.g_mdr = 1; c.ld_reg = 1; c.ld_cc = 1; end
      S23: begin c.aluk = 2'b11; c.g_alu = 1; c.ld_mdr = 1; end
      S16: c.we = 0;
      PAUSE1: c.ld_led = s.led;
      default: ;
    endcase
    return c;
  endfunction

  // Model: each instruction expands into its list of micro-steps when the previous list runs out.
  step_t plan[$];
  step_t cur;
  logic  model_ok = 1'b0;

  task automatic push(state_t s, int n, logic led);
    step_t t;
    t.st = s; t.ir5 = IR_5; t.ir11 = IR_11; t.led = led;
    for (int i = 0; i < n; i++) plan.push_back(t);
  endtask

  task automatic push_fetch();
    push(S18, 1, 0); push(S33, MW, 0); push(S35, 1, 0); push(S32, 1, 0);
  endtask

  task automatic finish_instr();
`ifdef ISDU_SINGLE_STEP_EN
    push(PAUSE1, 1, 0);
`else
    push_fetch();
`endif
  endtask

  task automatic expand();
    case (cur.st)
      HALTED: if (Run) push_fetch();
      S32: begin
        case (Opcode)
          4'b0001: begin push(S01, 1, 0); finish_instr(); end
          4'b0101: begin push(S05, 1, 0); finish_instr(); end
          4'b1001: begin push(S09, 1, 0); finish_instr(); end
          4'b0000: begin push(S00, 1, 0); if (BEN) push(S22, 1, 0); finish_instr(); end
          4'b1100: begin push(S12, 1, 0); finish_instr(); end
          4'b0100: begin push(S04, 1, 0); push(S21, 1, 0); finish_instr(); end
          4'b0110: begin push(S06, 1, 0); push(S25, MW, 0); push(S27, 1, 0); finish_instr(); end
          4'b0111: begin push(S07, 1, 0); push(S23, 1, 0); push(S16, MW, 0); finish_instr(); end
          4'b1101: push(PAUSE1, 1, 1);
          default: push_fetch();
        endcase
      end
      PAUSE1: push(Continue ? PAUSE2 : PAUSE1, 1, Continue ? 1'b0 : cur.led);
      PAUSE2: if (Continue) push(PAUSE2, 1, 0); else push_fetch();
      default: ;
    endcase
  endtask

  always @(posedge Clk) begin
    if (Reset) begin
      plan.delete();
      cur = '{HALTED, 1'b0, 1'b0, 1'b0};
      model_ok = 1'b1;
    end else if (model_ok) begin
      if (plan.size() == 0) expand();
      if (plan.size() > 0) cur = plan.pop_front();
    end
  end

  always @(negedge Clk) begin
    if (model_ok) begin
      check("ctl", 32'(act), 32'(exp_ctl(cur)));
      check("state", 32'(State), 32'(cur.st));
    end
  end

  int c_oe, c_we, c_ir, c_led, c_ldpc;
  always @(negedge Clk) begin
    if (!Mem_OE) c_oe++;
    if (!Mem_WE) c_we++;
    if (LD_IR) c_ir++;
    if (LD_LED) c_led++;
    if (LD_PC) c_ldpc++;
  end

  task automatic clr();
    c_oe = 0; c_we = 0; c_ir = 0; c_led = 0; c_ldpc = 0;
  endtask

  task automatic tick();
    @(posedge Clk); #2;
  endtask

  task automatic wait_cur(state_t s, int budget);
    for (int i = 0; i < budget; i++) begin
      tick();
      if (cur.st == s) return;
    end
    nchk++; nerr++;
    $display("FAIL wait_%s: got %s required %s", s.name(), cur.st.name(), s.name());
  endtask

  initial begin
    int n;
    Reset = 1; Run = 0; Continue = 0; Opcode = 4'b0001; IR_5 = 1; IR_11 = 0; BEN = 0;
    repeat (2) @(posedge Clk);
    #2 Reset = 0;

`ifndef ISDU_SINGLE_STEP_EN
    @(negedge Clk);
    check("rst_loads", {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED}, 0);
    check("rst_gates", {GatePC, GateMDR, GateALU, GateMARMUX}, 0);
    check("rst_strobes", {Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE}, 5'b00011);
    check("rst_state", 32'(State), 32'(ST_HALTED));

    tick(); clr(); Run = 1;
    tick(); Run = 0;
    wait_cur(S01, 20);
    check("fetch_oe_cycles", c_oe, 3);
    check("fetch_ir_cycles", c_ir, 1);
    @(negedge Clk);
    check("add_s01", {SR2MUX, ALUK, GateALU, LD_REG, LD_CC}, 6'b1_00_111);
    @(negedge Clk);
    check("add_then_s18", {GatePC, LD_MAR, LD_PC, LD_REG}, 4'b1110);

    tick(); Opcode = 4'b0000; BEN = 0;
    wait_cur(S00, 20);
    clr();
    @(negedge Clk);
    tick();
    check("br_nt_ldpc", c_ldpc, 0);
    @(negedge Clk);
    check("br_nt_s18", {GatePC, LD_PC}, 2'b11);
    BEN = 1;
    wait_cur(S22, 20);
    @(negedge Clk);
    check("br_t_s22", {PCMUX, ADDR2MUX, LD_PC}, 5'b10_10_1);

    tick(); Opcode = 4'b0111;
    wait_cur(S32, 20);
    clr();
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick(); n++;
      if (cur.st == S18) break;
    end
    check("str_len", n, 6);
    check("str_we_cycles", c_we, 3);
    check("str_oe_cycles", c_oe, 0);

    Opcode = 4'b1101; Continue = 1;
    wait_cur(S32, 20);
    clr();
    repeat (6) tick();
    check("pause_led_cycles", c_led, 1);
    check("pause_hold_ldpc", c_ldpc, 0);
    Continue = 0; Opcode = 4'b0111;
    @(negedge Clk);
    @(negedge Clk);
    check("pause_exit_s18", {GatePC, LD_MAR, LD_PC}, 3'b111);

    wait_cur(S16, 20);
    tick(); Reset = 1;
    tick(); Reset = 0;
    @(negedge Clk);
    check("abort_we", Mem_WE, 1);
    check("abort_loads", {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED}, 0);

    Opcode = 4'b1111;
    tick(); Run = 1;
    tick(); Run = 0;
    wait_cur(S32, 20);
    @(negedge Clk);
    @(negedge Clk);
    check("nop_s18", {GatePC, LD_MAR, LD_REG, LD_CC}, 4'b1100);
`endif

    for (int i = 0; i < 4000; i++) begin
      tick();
      Reset = ($urandom_range(0, 299) == 0);
      Run = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) == 0) Continue = ~Continue;
      if (cur.st == S18 || cur.st == HALTED) begin
        Opcode = 4'($urandom_range(0, 15));
        IR_5 = 1'($urandom_range(0, 1));
        IR_11 = 1'($urandom_range(0, 1));
        BEN = 1'($urandom_range(0, 1));
      end
    end
    tick();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
